muldiv_hilo: RTL and testbench

- Iterative multiply/divide unit that owns the architectural HI/LO registers.
- Sits downstream of the execute-stage controller outputs.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and computes multiplies and divides over WIDTH cycles.
- Exports a busy flag so the hazard unit stalls any later HI/LO reader or muldiv op.

---
 rtl/muldiv_hilo_pkg.sv | 24 ++
 rtl/muldiv_hilo_hilo_reg.sv | 41 ++++
 rtl/muldiv_hilo.sv | 223 ++++++++++++++++++++++
 tb/tb_muldiv_hilo.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_hilo_pkg
// Purpose  : Shared op-code and FSM state encodings for the HI/LO
//            multiply/divide unit.
// Contents : c_OP_* operation codes (3 bits), c_ST_* FSM states (1 bit).
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_hilo_pkg;

  // Operation codes carried on opE; 110 and 111 are no-ops.
  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  // FSM state encodings.
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

endpackage : muldiv_hilo_pkg
`default_nettype wire

// File: rtl/muldiv_hilo_hilo_reg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_reg
// Purpose  : Architectural HI/LO storage with independent write enables.
// Ports    : clk, rst (async, active-low)
//            hi_we / hi_d : write strobe and data for HI
//            lo_we / lo_d : write strobe and data for LO
//            hi / lo      : current register contents
// Revision : 1.0 - initial release
// ============================================================================
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hi_we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] lo_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (hi_we) r_hi <= hi_d;
      if (lo_we) r_lo <= lo_d;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule : hilo_reg
`default_nettype wire

// File: rtl/muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_hilo
// Purpose  : Iterative multiply/divide unit owning the HI/LO registers.
//            MULT/MULTU run shift-add, DIV/DIVU run restoring division,
//            each taking WIDTH cycles; MTHI/MTLO write in a single edge.
// Ports    : clk, rst (async, active-low)
//            startE, opE, srcaE, srcbE : E-stage request
//            cancel                    : abort in-flight op / suppress accept
//            busy                      : iterative op in progress
//            hi, lo                    : HI/LO register contents
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import muldiv_hilo_pkg::*;

  // FSM
  logic [0:0]         r_state;
  logic [0:0]         w_stateNext;
  logic [CNT_W-1:0]   r_cnt;

  // Operand / iteration state
  logic [2*WIDTH-1:0] r_acc;      // multiply accumulator {partial, multiplier}
  logic [WIDTH-1:0]   r_rem;      // divide partial remainder
  logic [WIDTH-1:0]   r_quo;      // divide dividend shifting into quotient
  logic [WIDTH-1:0]   r_opB;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   r_rawA;     // raw srcaE, needed for divide-by-zero HI
  logic               r_isDiv;
  logic               r_negRes;   // product / quotient needs negation
  logic               r_negRem;   // remainder takes dividend sign
  logic               r_divZero;

  // Decode
  logic               w_accept;
  logic               w_isMul;
  logic               w_isDiv;
  logic               w_signed;
  logic               w_negA;
  logic               w_negB;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;

  // Iteration datapath
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quoNext;
  logic               w_last;

  // Fixed-up results
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  // HI/LO write port
  logic               w_hiWe;
  logic               w_loWe;
  logic [WIDTH-1:0]   w_hiD;
  logic [WIDTH-1:0]   w_loD;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_accept = (r_state == c_ST_IDLE) && startE && !cancel;
  assign w_isMul  = (opE == c_OP_MULT) || (opE == c_OP_MULTU);
  assign w_isDiv  = (opE == c_OP_DIV)  || (opE == c_OP_DIVU);
  assign w_signed = (opE == c_OP_MULT) || (opE == c_OP_DIV);
  assign w_negA   = w_signed && srcaE[WIDTH-1];
  assign w_negB   = w_signed && srcbE[WIDTH-1];
  // Two's-complement negation read as unsigned yields the exact magnitude,
  // including the most-negative value (2^(WIDTH-1) needs WIDTH+1 bits signed
  // but fits WIDTH bits unsigned).
  assign w_absA   = w_negA ? (~srcaE + 1'b1) : srcaE;
  assign w_absB   = w_negB ? (~srcbE + 1'b1) : srcbE;

  // --------------------------------------------------------------------------
  // One iteration of each algorithm
  // --------------------------------------------------------------------------
  // Shift-add: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right with carry.
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_opB : {WIDTH{1'b0}})};
  assign w_accNext = {w_mulSum, r_acc[WIDTH-1:1]};

  // Restoring divide on a WIDTH+1-bit shifted partial remainder.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = w_shift >= {1'b0, r_opB};
  assign w_diff    = w_shift[WIDTH-1:0] - r_opB;
  assign w_remNext = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quoNext = {r_quo[WIDTH-2:0], w_ge};

  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_prod    = r_negRes ? (~w_accNext + 1'b1) : w_accNext;
  assign w_quoFix  = r_negRes ? (~w_quoNext + 1'b1) : w_quoNext;
  assign w_remFix  = r_negRem ? (~w_remNext + 1'b1) : w_remNext;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_ST_IDLE;
    else      r_state <= w_stateNext;
  end

  // FSM: next state
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept && (w_isMul || w_isDiv)) w_stateNext = c_ST_RUN;
      c_ST_RUN:  if (cancel || w_last)                 w_stateNext = c_ST_IDLE;
      default:   w_stateNext = c_ST_IDLE;
    endcase
  end

  // FSM: outputs (HI/LO write port)
  always_comb begin
    w_hiWe = 1'b0;
    w_loWe = 1'b0;
    w_hiD  = '0;
    w_loD  = '0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept && (opE == c_OP_MTHI)) begin
          w_hiWe = 1'b1;
          w_hiD  = srcaE;
        end
        if (w_accept && (opE == c_OP_MTLO)) begin
          w_loWe = 1'b1;
          w_loD  = srcaE;
        end
      end
      c_ST_RUN: begin
        // cancel on the final edge suppresses the write
        if (w_last && !cancel) begin
          w_hiWe = 1'b1;
          w_loWe = 1'b1;
          if (!r_isDiv) begin
            w_hiD = w_prod[2*WIDTH-1:WIDTH];
            w_loD = w_prod[WIDTH-1:0];
          end else if (r_divZero) begin
            w_hiD = r_rawA;
            w_loD = {WIDTH{1'b1}};
          end else begin
            w_hiD = w_remFix;
            w_loD = w_quoFix;
          end
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand latch and iteration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_opB     <= '0;
      r_rawA    <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
    end else if (w_accept && (w_isMul || w_isDiv)) begin
      r_cnt     <= '0;
      r_acc     <= {{WIDTH{1'b0}}, w_absA};
      r_rem     <= '0;
      r_quo     <= w_absA;
      r_opB     <= w_absB;
      r_rawA    <= srcaE;
      r_isDiv   <= w_isDiv;
      r_negRes  <= w_negA ^ w_negB;
      r_negRem  <= w_negA;
      r_divZero <= (srcbE == '0);
    end else if (r_state == c_ST_RUN) begin
      // Both datapaths step each cycle; only the one matching r_isDiv is
      // used at the final write.
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_accNext;
      r_rem <= w_remNext;
      r_quo <= w_quoNext;
    end
  end

  assign busy = (r_state == c_ST_RUN);

  hilo_reg #(
    .WIDTH (WIDTH)
  ) u_hiloReg (
    .clk   (clk),
    .rst   (rst),
    .hi_we (w_hiWe),
    .hi_d  (w_hiD),
    .lo_we (w_loWe),
    .lo_d  (w_loD),
    .hi    (hi),
    .lo    (lo)
  );

endmodule : muldiv_hilo
`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_hilo
// Purpose  : Self-checking bench for muldiv_hilo; directed cases plus
//            randomized ops checked against a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo;

  logic        clk;
  logic        rst;
  logic        startE;
  logic [2:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          failures;
  logic [31:0] expHi;
  logic [31:0] expLo;

  muldiv_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .startE (startE),
    .opE    (opE),
    .srcaE  (srcaE),
    .srcbE  (srcbE),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural effect of one completed op on HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin p = 64'(sa * sb); expHi = p[63:32]; expLo = p[31:0]; end
      3'b001: begin p = {32'd0, a} * {32'd0, b}; expHi = p[63:32]; expLo = p[31:0]; end
      3'b010, 3'b011: begin
        if (b == 32'd0) begin
          expLo = 32'hFFFF_FFFF;
          expHi = a;
        end else if (op == 3'b010) begin
          q = sa / sb;
          r = sa % sb;
          expLo = q[31:0];
          expHi = r[31:0];
        end else begin
          expLo = a / b;
          expHi = a % b;
        end
      end
      3'b100: expHi = a;
      3'b101: expLo = a;
      default: ;
    endcase
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    startE = 1'b1;
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    @(negedge clk);
    startE = 1'b0;
  endtask

  // Issue one op, measure busy length, check HI/LO against the model.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int n;
    start_op(op, a, b);
    model(op, a, b);
    n = 0;
    if (op[2] == 1'b0) begin
      while (busy && n < 100) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n !== 32) begin
        failures++;
        $display("FAIL %s busy_cycles: got %0d expected 32", name, n);
      end
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s busy: got %b expected 0", name, busy);
      end
    end
    checks++;
    if (hi !== expHi) begin
      failures++;
      $display("FAIL %s hi: got %h expected %h (a=%h b=%h op=%0d)", name, hi, expHi, a, b, op);
    end
    checks++;
    if (lo !== expLo) begin
      failures++;
      $display("FAIL %s lo: got %h expected %h (a=%h b=%h op=%0d)", name, lo, expLo, a, b, op);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++;
    if (hi !== 32'd0) begin failures++; $display("FAIL reset hi: got %h expected 0", hi); end
    checks++;
    if (lo !== 32'd0) begin failures++; $display("FAIL reset lo: got %h expected 0", lo); end
    @(negedge clk);
    rst = 1'b1;
    expHi = 32'd0;
    expLo = 32'd0;
  endtask

  task automatic test_mult();
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, "multu_maxx2");
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
  endtask

  task automatic test_div();
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run_op(3'b011, 32'd7, 32'd0, "divu_by0");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_neg1");
  endtask

  task automatic test_mt_back_to_back();
    @(negedge clk);
    startE = 1'b1; opE = 3'b100; srcaE = 32'h1234_5678; srcbE = 32'd0;
    @(negedge clk);
    expHi = 32'h1234_5678;
    checks++;
    if (hi !== expHi || busy !== 1'b0) begin
      failures++; $display("FAIL mthi: hi=%h busy=%b expected hi=%h busy=0", hi, busy, expHi);
    end
    opE = 3'b101; srcaE = 32'h9ABC_DEF0;
    @(negedge clk);
    startE = 1'b0;
    expLo = 32'h9ABC_DEF0;
    checks++;
    if (lo !== expLo || hi !== expHi || busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", hi, lo, busy, expHi, expLo);
    end
    // no-op codes must leave everything alone
    run_op(3'b110, 32'hAAAA_AAAA, 32'd1, "nop110");
    run_op(3'b111, 32'h5555_5555, 32'd1, "nop111");
  endtask

  task automatic test_cancel();
    // cancel at RUN cycle 10 of DIVU 100/3
    start_op(3'b011, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL cancel_prebusy: got %b expected 1", busy); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    repeat (40) @(negedge clk);
    checks++;
    if (hi !== expHi || lo !== expLo || busy !== 1'b0) begin
      failures++;
      $display("FAIL cancel_hilo: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", hi, lo, busy, expHi, expLo);
    end
    // cancel coincident with the final iteration edge
    start_op(3'b001, 32'd11, 32'd13);
    repeat (31) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (hi !== expHi || lo !== expLo || busy !== 1'b0) begin
      failures++;
      $display("FAIL cancel_last: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", hi, lo, busy, expHi, expLo);
    end
    // cancel in IDLE beats startE
    @(negedge clk);
    startE = 1'b1; cancel = 1'b1; opE = 3'b100; srcaE = 32'hCAFE_F00D;
    @(negedge clk);
    startE = 1'b0; cancel = 1'b0;
    checks++;
    if (hi !== expHi || busy !== 1'b0) begin
      failures++; $display("FAIL cancel_idle: hi=%h busy=%b expected hi=%h busy=0", hi, busy, expHi);
    end
  endtask

  task automatic test_start_during_run();
    int n;
    start_op(3'b001, 32'h0001_0003, 32'h0000_0101);
    model(3'b001, 32'h0001_0003, 32'h0000_0101);
    n = 1;
    repeat (4) @(negedge clk);
    n += 4;
    startE = 1'b1; opE = 3'b010; srcaE = 32'd50; srcbE = 32'd7;
    @(negedge clk);
    n++;
    startE = 1'b0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== 33) begin failures++; $display("FAIL ignore_start_len: got %0d expected 33", n); end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== expHi || lo !== expLo) begin
      failures++;
      $display("FAIL ignore_start: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", hi, lo, busy, expHi, expLo);
    end
  endtask

  task automatic test_async_reset();
    start_op(3'b000, 32'h1234_5678, 32'h8765_4321);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    expHi = 32'd0;
    expLo = 32'd0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL async_reset: hi=%h lo=%h busy=%b expected all 0", hi, lo, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(3'b001, 32'd6, 32'd7, "multu_6x7_after_reset");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    startE   = 1'b0;
    opE      = 3'b000;
    srcaE    = '0;
    srcbE    = '0;
    cancel   = 1'b0;
    expHi    = '0;
    expLo    = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mt_back_to_back();
    test_cancel();
    test_start_during_run();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_muldiv_hilo
`default_nettype wire
